fpu_result_queue: RTL and testbench
===================================

Name: fpu_result_queue

Overview:
- Registered output stage directly downstream of the combinational subtractor.
- Captures each {resultSub, errorSub, overflowSub} triple on a valid/ready handshake and buffers it in a small FIFO.
- Presents results to the consumer through a second valid/ready handshake.
- Keeps sticky exception flags, software-clearable, for the whole stream.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- CW, 3: count width; must equal clog2(DEPTH)+1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer presents a result this cycle
- in_ready  output  1  queue can accept; high when not full
- in_result  input  32  IEEE-754 single result (subtractor resultSub)
- in_error  input  1  subtractor errorSub
- in_overflow  input  1  subtractor overflowSub
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer accepts head this cycle
- out_result  output  32  head result
- out_error  output  1  head error bit
- out_overflow  output  1  head overflow bit
- count  output  CW  entries held, 0..DEPTH
- flag_clear  input  1  synchronous clear of all sticky flags
- sticky_error  output  1  any accepted entry had in_error=1
- sticky_overflow  output  1  any accepted entry had in_overflow=1
- sticky_nan  output  1  any accepted result had exp=8'hFF, frac!=0
- sticky_inf  output  1  any accepted result had exp=8'hFF, frac=0

Behaviour:
- Reset (rst_n low, async):
  - Pointers and count are 0; out_valid=0; in_ready=1.
  - out_result=0, out_error=0, out_overflow=0.
  - All sticky flags are 0.
  - Entries held when reset asserts are discarded. No partial transfer completes.
- Push: occurs when in_valid & in_ready at the clk rising edge. The entry {in_result, in_error, in_overflow} is written at wr_ptr, then wr_ptr increments modulo DEPTH.
- Pop: occurs when out_valid & out_ready at the edge. rd_ptr increments modulo DEPTH.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from count.
- in_ready = (count != DEPTH). It is purely a function of registered state and never depends on out_ready, so there is no combinational ready path.
- out_valid = (count != 0). out_* are driven from mem[rd_ptr] when out_valid=1 and forced to 0 when empty.
- Latency: an entry pushed at edge N is visible on out_* after edge N, with out_valid high in cycle N+1. There is no bypass when empty.
- Count update:
  - +1 on push only, -1 on pop only.
  - Unchanged on simultaneous push and pop. This is legal at any count 1..DEPTH-1.
  - When full, push is blocked and pop proceeds. When empty, pop is blocked and push proceeds.
- Holding rules:
  - Producer holds in_* stable while in_valid & !in_ready.
  - out_* stay stable while out_valid & !out_ready.
- Sticky flags:
  - Each flag is set on a push whose entry matches its condition.
  - Classification uses in_result[30:23] and in_result[22:0] as written to the FIFO.
  - flag_clear zeroes all flags at the edge.
  - If flag_clear and a flag-setting push occur at the same edge, set wins and that flag reads 1 afterwards.
  - Flags are not affected by pops.

Optional Feature:
- Macro: FPU_RESULT_FTZ_EN.
- With the macro defined:
  - An accepted result with exp=0 and frac!=0 (subnormal) is written as signed zero, {sign, 31'b0}.
  - An extra output port sticky_underflow (1 bit) is added. It follows the same set/clear/priority rules as the other sticky flags and resets to 0.
- Without the macro: results are stored bit-exact and port sticky_underflow does not exist.

Test Plan:
- Reset then single push of 32'h40400000, err=0, ovf=0, with out_ready=1:
  - out_valid rises the cycle after the push, with out_result=32'h40400000.
  - count goes 0->1->0.
  - All sticky flags stay 0.
- Fill with out_ready=0 and DEPTH=4, pushing 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000:
  - in_ready=0 and count=4.
  - A 5th in_valid is not accepted.
  - Draining returns the four values in order and then out_valid=0.
- Continuous push and pop at count=2 for 10 cycles:
  - count holds at 2.
  - Pointers wrap past DEPTH.
  - The output order matches the input order.
- Push 32'h7FC00000 with err=1, then 32'hFF800000 with ovf=1:
  - sticky_nan, sticky_error, sticky_inf and sticky_overflow are all 1.
  - flag_clear for one cycle returns all four to 0.
- flag_clear asserted in the same cycle as a push of 32'h7F800000 with ovf=1:
  - sticky_inf=1 and sticky_overflow=1 after the edge.
- Assert rst_n low mid-stream with count=3:
  - Immediately count=0, out_valid=0, out_result=0, in_ready=1, and flags are 0.
- With FPU_RESULT_FTZ_EN defined, push 32'h80000001:
  - out_result=32'h80000000 and sticky_underflow=1.

Source files
------------

// File: rtl/fpu_result_queue_if.sv
// Producer and consumer handshake bundle for fpu_result_queue.
// The slave modport is the queue side. The master modport is the side that drives results in and takes them out.
interface fpu_result_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_error;
  logic        in_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_error;
  logic        out_overflow;

  modport slave (
    input  in_valid, in_result, in_error, in_overflow, out_ready,
    output in_ready, out_valid, out_result, out_error, out_overflow
  );

  modport master (
    output in_valid, in_result, in_error, in_overflow, out_ready,
    input  in_ready, out_valid, out_result, out_error, out_overflow
  );
endinterface

// File: rtl/fpu_result_queue.sv
// Registered FIFO output stage for the FPU subtractor, with sticky exception flags.
// Optional macro FPU_RESULT_FTZ_EN: subnormal results are flushed to zero and sticky_underflow is added.
module fpu_result_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  fpu_result_queue_if.slave q,
  output logic [CW-1:0] count,
  input  logic          flag_clear,
  output logic          sticky_error,
  output logic          sticky_overflow,
  output logic          sticky_nan,
  output logic          sticky_inf
`ifdef FPU_RESULT_FTZ_EN
  ,
  output logic          sticky_underflow
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  function automatic logic is_nan(input logic [31:0] r);
    return (r[30:23] == 8'hFF) && (r[22:0] != 23'h000000);
  endfunction

  function automatic logic is_inf(input logic [31:0] r);
    return (r[30:23] == 8'hFF) && (r[22:0] == 23'h000000);
  endfunction

  function automatic logic is_subnormal(input logic [31:0] r);
    return (r[30:23] == 8'h00) && (r[22:0] != 23'h000000);
  endfunction

  // Each entry is {result, error, overflow}.
  logic [33:0]   mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          sticky_error_r;
  logic          sticky_overflow_r;
  logic          sticky_nan_r;
  logic          sticky_inf_r;
  logic          in_ready_s;
  logic          out_valid_s;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   wr_data_s;

  assign in_ready_s  = (count_r != CNT_FULL);
  assign out_valid_s = (count_r != CNT_ZERO);
  assign push_s      = q.in_valid & in_ready_s;
  assign pop_s       = out_valid_s & q.out_ready;

  // Select the result value that is stored and classified.
  always_comb begin
    wr_data_s = q.in_result;
`ifdef FPU_RESULT_FTZ_EN
    if (is_subnormal(q.in_result)) begin
      wr_data_s = {q.in_result[31], 31'h00000000};
    end else begin
      wr_data_s = q.in_result;
    end
`endif
  end

  // Storage array. Entries are not reset because the pointers and count decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {wr_data_s, q.in_error, q.in_overflow};
    end
  end

  // Pointer and occupancy state. The pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      else        wr_ptr_r <= wr_ptr_r;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      else        rd_ptr_r <= rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky flags. A setting push overrides flag_clear on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_error_r    <= 1'b0;
      sticky_overflow_r <= 1'b0;
      sticky_nan_r      <= 1'b0;
      sticky_inf_r      <= 1'b0;
    end else begin
      sticky_error_r    <= (sticky_error_r    & ~flag_clear) | (push_s & q.in_error);
      sticky_overflow_r <= (sticky_overflow_r & ~flag_clear) | (push_s & q.in_overflow);
      sticky_nan_r      <= (sticky_nan_r      & ~flag_clear) | (push_s & is_nan(wr_data_s));
      sticky_inf_r      <= (sticky_inf_r      & ~flag_clear) | (push_s & is_inf(wr_data_s));
    end
  end

`ifdef FPU_RESULT_FTZ_EN
  logic sticky_underflow_r;

  // Underflow is detected on the raw input, before it is flushed to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_underflow_r <= 1'b0;
    end else begin
      sticky_underflow_r <= (sticky_underflow_r & ~flag_clear) | (push_s & is_subnormal(q.in_result));
    end
  end

  assign sticky_underflow = sticky_underflow_r;
`endif

  // Head entry goes to the consumer. The output is forced to zero when the queue is empty.
  always_comb begin
    if (out_valid_s) begin
      {q.out_result, q.out_error, q.out_overflow} = mem_r[rd_ptr_r];
    end else begin
      {q.out_result, q.out_error, q.out_overflow} = 34'h000000000;
    end
  end

  assign q.in_ready       = in_ready_s;
  assign q.out_valid      = out_valid_s;
  assign count            = count_r;
  assign sticky_error     = sticky_error_r;
  assign sticky_overflow  = sticky_overflow_r;
  assign sticky_nan       = sticky_nan_r;
  assign sticky_inf       = sticky_inf_r;
endmodule

// File: tb/tb_fpu_result_queue.sv
// Directed self-checking bench for fpu_result_queue (DEPTH=4).
// With FPU_RESULT_FTZ_EN defined, it also checks flush-to-zero and sticky_underflow.
module tb_fpu_result_queue;
  logic       clk;
  logic       rst_n;
  logic       flag_clear;
  logic [2:0] count;
  logic       sticky_error, sticky_overflow, sticky_nan, sticky_inf;
`ifdef FPU_RESULT_FTZ_EN
  logic       sticky_underflow;
`endif
  int tests;
  int fails;

  fpu_result_queue_if bus();

  fpu_result_queue #(.DEPTH(4), .CW(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .q               (bus),
    .count           (count),
    .flag_clear      (flag_clear),
    .sticky_error    (sticky_error),
    .sticky_overflow (sticky_overflow),
    .sticky_nan      (sticky_nan),
    .sticky_inf      (sticky_inf)
`ifdef FPU_RESULT_FTZ_EN
    ,
    .sticky_underflow(sticky_underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flag_clear = 1'b0;
    bus.in_valid = 1'b0; bus.in_result = 32'h0; bus.in_error = 1'b0;
    bus.in_overflow = 1'b0; bus.out_ready = 1'b0;
    #12;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count: actual=%0d required=0", count); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: actual=%b required=1", bus.in_ready); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: actual=%b required=0", bus.out_valid); end
    tests++; if ({bus.out_result, bus.out_error, bus.out_overflow} !== 34'h0) begin fails++; $display("FAIL reset_out: actual=%h required=0", bus.out_result); end
    tests++; if ({sticky_error, sticky_overflow, sticky_nan, sticky_inf} !== 4'b0000) begin fails++; $display("FAIL reset_flags: actual=%b required=0000", {sticky_error, sticky_overflow, sticky_nan, sticky_inf}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_result = 32'h40400000;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL single_no_bypass: actual=%b required=0", bus.out_valid); end
    step();
    bus.in_valid = 1'b0;
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: actual=%b required=1", bus.out_valid); end
    tests++; if (bus.out_result !== 32'h40400000) begin fails++; $display("FAIL single_result: actual=%h required=40400000", bus.out_result); end
    tests++; if (count !== 3'd1) begin fails++; $display("FAIL single_count1: actual=%0d required=1", count); end
    step();
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL single_count0: actual=%0d required=0", count); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL single_empty: actual=%b required=0", bus.out_valid); end
    tests++; if ({sticky_error, sticky_overflow, sticky_nan, sticky_inf} !== 4'b0000) begin fails++; $display("FAIL single_flags: actual=%b required=0000", {sticky_error, sticky_overflow, sticky_nan, sticky_inf}); end
  endtask

  task automatic test_fill();
    logic [31:0] vals [4];
    vals[0] = 32'h3F800000; vals[1] = 32'h40000000;
    vals[2] = 32'h40400000; vals[3] = 32'h40800000;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_result = vals[i];
      step();
    end
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL fill_count: actual=%0d required=4", count); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL fill_in_ready: actual=%b required=0", bus.in_ready); end
    bus.in_result = 32'h12345678;
    step();
    bus.in_valid = 1'b0;
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL fill_fifth_blocked: actual=%0d required=4", count); end
    tests++; if (bus.out_result !== 32'h3F800000) begin fails++; $display("FAIL fill_hold: actual=%h required=3f800000", bus.out_result); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (bus.out_valid !== 1'b1 || bus.out_result !== vals[i]) begin fails++; $display("FAIL fill_drain%0d: actual=%b/%h required=1/%h", i, bus.out_valid, bus.out_result, vals[i]); end
      step();
    end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL fill_drained: actual=%b required=0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [$];
    logic [31:0] v;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_result = 32'h41000000; step(); exp_q.push_back(32'h41000000);
    bus.in_result = 32'h41100000; step(); exp_q.push_back(32'h41100000);
    for (int i = 0; i < 10; i++) begin
      v = 32'h42000000 + 32'(i);
      bus.in_valid = 1'b1; bus.in_result = v; bus.out_ready = 1'b1;
      tests++; if (count !== 3'd2) begin fails++; $display("FAIL b2b_count%0d: actual=%0d required=2", i, count); end
      tests++; if (bus.out_result !== exp_q[0]) begin fails++; $display("FAIL b2b_order%0d: actual=%h required=%h", i, bus.out_result, exp_q[0]); end
      step();
      exp_q.push_back(v);
      void'(exp_q.pop_front());
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests++; if (bus.out_valid !== 1'b1 || bus.out_result !== exp_q[0]) begin fails++; $display("FAIL b2b_drain%0d: actual=%h required=%h", i, bus.out_result, exp_q[0]); end
      step();
      void'(exp_q.pop_front());
    end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL b2b_empty: actual=%0d required=0", count); end
  endtask

  task automatic test_sticky();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_result = 32'h7FC00000; bus.in_error = 1'b1; bus.in_overflow = 1'b0;
    step();
    tests++; if (bus.out_error !== 1'b1 || bus.out_overflow !== 1'b0) begin fails++; $display("FAIL sticky_head_bits: actual=%b%b required=10", bus.out_error, bus.out_overflow); end
    bus.in_result = 32'hFF800000; bus.in_error = 1'b0; bus.in_overflow = 1'b1;
    step();
    bus.in_valid = 1'b0; bus.in_overflow = 1'b0;
    tests++; if ({sticky_error, sticky_overflow, sticky_nan, sticky_inf} !== 4'b1111) begin fails++; $display("FAIL sticky_set: actual=%b required=1111", {sticky_error, sticky_overflow, sticky_nan, sticky_inf}); end
    flag_clear = 1'b1;
    step();
    flag_clear = 1'b0;
    tests++; if ({sticky_error, sticky_overflow, sticky_nan, sticky_inf} !== 4'b0000) begin fails++; $display("FAIL sticky_clear: actual=%b required=0000", {sticky_error, sticky_overflow, sticky_nan, sticky_inf}); end
  endtask

  task automatic test_clear_priority();
    flag_clear = 1'b1;
    bus.in_valid = 1'b1; bus.in_result = 32'h7F800000; bus.in_overflow = 1'b1;
    step();
    flag_clear = 1'b0; bus.in_valid = 1'b0; bus.in_overflow = 1'b0;
    tests++; if ({sticky_error, sticky_overflow, sticky_nan, sticky_inf} !== 4'b0101) begin fails++; $display("FAIL clear_priority: actual=%b required=0101", {sticky_error, sticky_overflow, sticky_nan, sticky_inf}); end
    step();
  endtask

  task automatic test_midreset();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_result = 32'h3F800000; step();
    bus.in_result = 32'h7F800000; step();
    bus.in_result = 32'h40000000; step();
    bus.in_valid = 1'b0;
    tests++; if (count !== 3'd3 || sticky_inf !== 1'b1) begin fails++; $display("FAIL midreset_pre: actual=%0d/%b required=3/1", count, sticky_inf); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin fails++; $display("FAIL midreset_state: actual=%0d/%b/%b required=0/0/1", count, bus.out_valid, bus.in_ready); end
    tests++; if (bus.out_result !== 32'h0) begin fails++; $display("FAIL midreset_result: actual=%h required=0", bus.out_result); end
    tests++; if ({sticky_error, sticky_overflow, sticky_nan, sticky_inf} !== 4'b0000) begin fails++; $display("FAIL midreset_flags: actual=%b required=0000", {sticky_error, sticky_overflow, sticky_nan, sticky_inf}); end
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_subnormal();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_result = 32'h80000001;
    step();
    bus.in_valid = 1'b0;
`ifdef FPU_RESULT_FTZ_EN
    tests++; if (bus.out_result !== 32'h80000000) begin fails++; $display("FAIL ftz_result: actual=%h required=80000000", bus.out_result); end
    tests++; if (sticky_underflow !== 1'b1) begin fails++; $display("FAIL ftz_underflow: actual=%b required=1", sticky_underflow); end
`else
    tests++; if (bus.out_result !== 32'h80000001) begin fails++; $display("FAIL subnormal_exact: actual=%h required=80000001", bus.out_result); end
`endif
    step();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_sticky();
    test_clear_priority();
    test_midreset();
    test_subnormal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
